// File: rtl/amiga_rst_pkg.sv
// Shared types and constants for the Amiga reset sequencer.
// Holds the FSM encodings and the retry counter width.
package amiga_rst_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_SDRAM_UP  = 3'd3,
    S_SYS_UP    = 3'd4,
    S_RUN       = 3'd5,
    S_HOLD      = 3'd6
  } state_e;

endpackage

// File: rtl/amiga_sync2.sv
// Two-flop bit synchronizer, async active-low reset to 0.
// Brings an asynchronous level into the clk domain.
module amiga_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Shift the async level through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/amiga_rst_seq.sv
// PLL-lock and power-on reset sequencer, clocked from the board clock.
// Releases SDRAM, chipset and CPU resets in order once lock is stable.
module amiga_rst_seq
  import amiga_rst_pkg::*;
#(
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int STAGE_GAP_CYC    = 64,
  parameter int CNT_W            = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               ext_rst_req,
  output logic               pll_rst,
  output logic               sdram_rst_n,
  output logic               sys_rst_n,
  output logic               cpu_rst_n,
  output logic [STATE_W-1:0] state,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] PLL_LAST =
    CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(STAGE_GAP_CYC - 1);

  logic lock_s;

  amiga_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               retry_inc;
  logic               pll_rst_q, pll_rst_d;
  logic               sdram_q, sdram_d;
  logic               sys_q, sys_d;
  logic               cpu_q, cpu_d;

  // Next state: lock loss beats ext request beats counter expiry.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_PLL_RST;
          retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) state_d = S_PLL_RST;
        else if (cnt_q == STB_LAST) state_d = S_SDRAM_UP;
      end
      S_SDRAM_UP: begin
        if (!lock_s) begin
          state_d   = S_PLL_RST;
          retry_inc = 1'b1;
        end else if (ext_rst_req) begin
          state_d = S_HOLD;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_SYS_UP;
        end
      end
      S_SYS_UP: begin
        if (!lock_s) begin
          state_d   = S_PLL_RST;
          retry_inc = 1'b1;
        end else if (ext_rst_req) begin
          state_d = S_HOLD;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d   = S_PLL_RST;
          retry_inc = 1'b1;
        end else if (ext_rst_req) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d   = S_PLL_RST;
          retry_inc = 1'b1;
        end else if (!ext_rst_req) begin
          state_d = S_SDRAM_UP;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
  end

  // Counter restarts on entry; retry count saturates.
  always_comb begin
    cnt_d   = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    retry_d = retry_q;
    if (retry_inc && (retry_q != '1)) begin
      retry_d = retry_q + 1'b1;
    end
  end

  // Output levels follow the state being entered.
  always_comb begin
    pll_rst_d = 1'b0;
    sdram_d   = 1'b0;
    sys_d     = 1'b0;
    cpu_d     = 1'b0;
    unique case (state_d)
      S_PLL_RST:  pll_rst_d = 1'b1;
      S_SDRAM_UP: sdram_d = 1'b1;
      S_SYS_UP: begin
        sdram_d = 1'b1;
        sys_d   = 1'b1;
      end
      S_RUN: begin
        sdram_d = 1'b1;
        sys_d   = 1'b1;
        cpu_d   = 1'b1;
      end
      S_HOLD:     sdram_d = 1'b1;
      default: begin
        pll_rst_d = 1'b0;
      end
    endcase
  end

  // State, counter, retry count and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sdram_q   <= 1'b0;
      sys_q     <= 1'b0;
      cpu_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sdram_q   <= sdram_d;
      sys_q     <= sys_d;
      cpu_q     <= cpu_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sdram_rst_n = sdram_q;
  assign sys_rst_n   = sys_q;
  assign cpu_rst_n   = cpu_q;
  assign state       = state_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_amiga_rst_seq.sv
// Testbench for amiga_rst_seq with a behavioural reference model.
// Directed scenarios plus a per-cycle compare against the model.
module tb_amiga_rst_seq;

  localparam int PR = 4;
  localparam int TO = 32;
  localparam int ST = 8;
  localparam int GP = 2;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       ext_rst_req;
  logic       pll_rst;
  logic       sdram_rst_n;
  logic       sys_rst_n;
  logic       cpu_rst_n;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  int checks;
  int failures;

  amiga_rst_seq #(
    .PLL_RST_CYC      (PR),
    .LOCK_TIMEOUT_CYC (TO),
    .LOCK_STABLE_CYC  (ST),
    .STAGE_GAP_CYC    (GP),
    .CNT_W            (17)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .ext_rst_req (ext_rst_req),
    .pll_rst     (pll_rst),
    .sdram_rst_n (sdram_rst_n),
    .sys_rst_n   (sys_rst_n),
    .cpu_rst_n   (cpu_rst_n),
    .state       (state),
    .retry_cnt   (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int got,
                       input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, got, exp, $time);
    end
  endtask

  // Behavioural model: phase number, time spent in phase,
  // a two-deep history of the raw lock input, and retries.
  // Output levels per phase: {pll_rst, sdram, sys, cpu}.
  localparam logic [3:0] OUT_TBL [0:6] = '{
    4'b1000, 4'b0000, 4'b0000, 4'b0100,
    4'b0110, 4'b0111, 4'b0100
  };

  int   m_ph;
  int   m_age;
  int   m_retry;
  bit   h1, h2, ls;
  int   nxt;
  bit   bump;
  logic [3:0] m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_age = 0; m_retry = 0;
      h1 = 0; h2 = 0;
    end else begin
      ls = h2; h2 = h1; h1 = pll_locked;
      nxt = m_ph; bump = 0;
      if (m_ph >= 2 && !ls) begin
        nxt = 0;
        bump = (m_ph >= 3);
      end else if (ext_rst_req && m_ph >= 3 && m_ph <= 5) begin
        nxt = 6;
      end else begin
        case (m_ph)
          0: if (m_age == PR - 1) nxt = 1;
          1: begin
            if (ls) nxt = 2;
            else if (m_age == TO - 1) begin
              nxt = 0; bump = 1;
            end
          end
          2: if (m_age == ST - 1) nxt = 3;
          3: if (m_age == GP - 1) nxt = 4;
          4: if (m_age == GP - 1) nxt = 5;
          6: if (!ext_rst_req) nxt = 3;
          default: ;
        endcase
      end
      if (bump && m_retry < 15) m_retry++;
      m_age = (nxt != m_ph) ? 0 : m_age + 1;
      m_ph = nxt;
    end
  end

  bit sdram_seen;
  bit rel_seen;

  // Per-cycle compare against the model, away from the edge.
  always @(negedge clk) begin
    m_out = OUT_TBL[m_ph];
    check("state", int'(state), m_ph);
    check("pll_rst", int'(pll_rst), int'(m_out[3]));
    check("sdram_rst_n", int'(sdram_rst_n), int'(m_out[2]));
    check("sys_rst_n", int'(sys_rst_n), int'(m_out[1]));
    check("cpu_rst_n", int'(cpu_rst_n), int'(m_out[0]));
    check("retry_cnt", int'(retry_cnt), m_retry);
    if (sdram_rst_n) sdram_seen = 1;
    if (sdram_rst_n || sys_rst_n || cpu_rst_n) rel_seen = 1;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while (int'(state) != s && n < budget) begin
      edges(1);
      n++;
    end
    check("reach_state", int'(state), s);
  endtask

  task automatic chk_outs(input string nm, input int st,
                          input int pr, input int sd,
                          input int sy, input int cp);
    check({nm, "_state"}, int'(state), st);
    check({nm, "_pll_rst"}, int'(pll_rst), pr);
    check({nm, "_sdram"}, int'(sdram_rst_n), sd);
    check({nm, "_sys"}, int'(sys_rst_n), sy);
    check({nm, "_cpu"}, int'(cpu_rst_n), cp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 0; pll_locked = 0; ext_rst_req = 0;
    edges(2);
    chk_outs("reset", 0, 1, 0, 0, 0);
    check("reset_retry", int'(retry_cnt), 0);

    // Cold start with lock already high.
    pll_locked = 1;
    #1 rst_n = 1;
    edges(3);
    chk_outs("cold_e3", 0, 1, 0, 0, 0);
    edges(1);
    chk_outs("cold_e4", 1, 0, 0, 0, 0);
    edges(1);
    chk_outs("cold_stable", 2, 0, 0, 0, 0);
    edges(7);
    chk_outs("cold_e12", 2, 0, 0, 0, 0);
    edges(1);
    chk_outs("cold_sdram", 3, 0, 1, 0, 0);
    edges(2);
    chk_outs("cold_sys", 4, 0, 1, 1, 0);
    edges(2);
    chk_outs("cold_run", 5, 0, 1, 1, 1);
    check("cold_retry", int'(retry_cnt), 0);

    // External reset request pulse of 10 cycles.
    #1 ext_rst_req = 1;
    edges(1);
    chk_outs("ext_hold", 6, 0, 1, 0, 0);
    edges(9);
    #1 ext_rst_req = 0;
    edges(1);
    chk_outs("ext_sdram", 3, 0, 1, 0, 0);
    edges(2);
    chk_outs("ext_sys", 4, 0, 1, 1, 0);
    edges(2);
    chk_outs("ext_run", 5, 0, 1, 1, 1);

    // Lock loss in RUN.
    #1 pll_locked = 0;
    edges(2);
    chk_outs("loss_pre", 5, 0, 1, 1, 1);
    edges(1);
    chk_outs("loss_fall", 0, 1, 0, 0, 0);
    check("loss_retry", int'(retry_cnt), 1);
    edges(2);
    #1 pll_locked = 1;

    // Glitch in STABLE: back to PLL_RST, retry unchanged.
    sdram_seen = 0;
    wait_state(2, 60);
    edges(3);
    #1 pll_locked = 0;
    edges(3);
    #1 pll_locked = 1;
    chk_outs("glitch", 0, 1, 0, 0, 0);
    check("glitch_retry", int'(retry_cnt), 1);
    check("glitch_no_sdram", int'(sdram_seen), 0);
    wait_state(5, 200);
    check("glitch_rerun_retry", int'(retry_cnt), 1);

    // Lock loss and ext request on the same edge.
    #1 pll_locked = 0;
    edges(2);
    #1 ext_rst_req = 1;
    edges(1);
    chk_outs("simul", 0, 1, 0, 0, 0);
    check("simul_retry", int'(retry_cnt), 2);
    #1 ext_rst_req = 0;
    pll_locked = 1;

    // Async reset while in SYS_UP.
    wait_state(4, 200);
    #1 rst_n = 0;
    #1;
    chk_outs("midrst", 0, 1, 0, 0, 0);
    check("midrst_retry", int'(retry_cnt), 0);

    // No lock at all: periodic PLL resets, retry saturates.
    pll_locked = 0;
    edges(1);
    #1 rst_n = 1;
    rel_seen = 0;
    edges(4);
    chk_outs("nolock_e4", 1, 0, 0, 0, 0);
    edges(31);
    chk_outs("nolock_e35", 1, 0, 0, 0, 0);
    check("nolock_r0", int'(retry_cnt), 0);
    edges(1);
    chk_outs("nolock_e36", 0, 1, 0, 0, 0);
    check("nolock_r1", int'(retry_cnt), 1);
    edges(4);
    chk_outs("nolock_e40", 1, 0, 0, 0, 0);
    edges(499);
    check("nolock_r14", int'(retry_cnt), 14);
    edges(1);
    check("nolock_r15", int'(retry_cnt), 15);
    check("nolock_e540_pll", int'(pll_rst), 1);
    edges(36);
    check("nolock_sat", int'(retry_cnt), 15);
    check("nolock_e576_pll", int'(pll_rst), 1);
    check("nolock_no_release", int'(rel_seen), 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
